// File: rtl/fp_round_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_round_pipe_if
//  Handshake and data bundle between the unrounded add/sub result producer,
//  the rounding pipeline and the FPU writeback.
//  Signal names carry the direction seen from the rounding pipeline.
//  Signals:
//   in_valid_i   producer -> pipe   urnd_i/rnd_i valid
//   in_ready_o   pipe -> producer   pipeline can accept
//   urnd_i       producer -> pipe   {u_result, guard, sticky, round_en, invalid, exp_cout[1:0]}
//   rnd_i        producer -> pipe   rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM)
//   out_valid_o  pipe -> writeback  result valid
//   out_ready_i  writeback -> pipe  downstream accepts
//   result_o     pipe -> writeback  rounded result
//   fflags_o     pipe -> writeback  {NV, DZ, OF, UF, NX}
//  Modports: slave = rounding pipeline, master = surrounding logic / bench.
// ---------------------------------------------------------------------------
interface fp_round_pipe_if #(
   parameter int unsigned FP_WIDTH = 32'd32
);
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [FP_WIDTH+5:0]   urnd_i;
   logic [2:0]            rnd_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [FP_WIDTH-1:0]   result_o;
   logic [4:0]            fflags_o;

   modport slave (
      input  in_valid_i, urnd_i, rnd_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, fflags_o
   );

   modport master (
      output in_valid_i, urnd_i, rnd_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, fflags_o
   );
endinterface

// File: rtl/fp_round_pipe.sv
// ---------------------------------------------------------------------------
// fp_round_pipe
//  Applies IEEE-754 rounding to an unrounded add/sub result, handles the
//  exponent carry from the mantissa increment, saturates overflow/underflow
//  and builds the exception flags. Valid/ready pipeline, one result per cycle:
//   S1 registers the input together with the round-up decision,
//   S2 registers the incremented {exp, mant},
//   the output stage resolves overflow/underflow/specials into result/fflags.
//  Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset, discards every entry
//   flush_i  synchronous kill of all in-flight entries (input that cycle ignored)
//   bus      fp_round_pipe_if.slave (see interface for members)
//  Parameter FP_FORMAT: 0 FP32, 1 FP64, 2 FP16, 3 BF16.
//  Optional macro FP_RND_SKID_EN: adds a one-entry skid buffer ahead of S1 so
//   that in_ready_o comes straight from a flop.
// ---------------------------------------------------------------------------
module fp_round_pipe #(
   parameter int unsigned FP_FORMAT = 32'd0
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           flush_i,
   fp_round_pipe_if.slave bus
);

   function automatic int unsigned exp_bits(input int unsigned fmt);
      case (fmt)
         32'd1:   return 32'd11;
         32'd2:   return 32'd5;
         32'd3:   return 32'd8;
         default: return 32'd8;
      endcase
   endfunction

   function automatic int unsigned man_bits(input int unsigned fmt);
      case (fmt)
         32'd1:   return 32'd52;
         32'd2:   return 32'd10;
         32'd3:   return 32'd7;
         default: return 32'd23;
      endcase
   endfunction

   localparam int unsigned EXP_W  = exp_bits(FP_FORMAT);
   localparam int unsigned MANT_W = man_bits(FP_FORMAT);
   localparam int unsigned EM_W   = EXP_W + MANT_W;
   localparam int unsigned FP_W   = EM_W + 32'd1;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam logic [EM_W-1:0] INF_EM = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};
   localparam logic [EM_W-1:0] MAX_EM = {{(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};

   // ---------------- handshake ----------------
   logic adv_out, adv2, adv1;
   logic out_valid_q, v2_q, v1_q;

   // A stage may load when empty or when its content moves on this edge.
   assign adv_out = ~out_valid_q | bus.out_ready_i;
   assign adv2    = ~v2_q | adv_out;
   assign adv1    = ~v1_q | adv2;

   // ---------------- input source ----------------
   logic              src_valid;
   logic [FP_W+5:0]   src_urnd;
   logic [2:0]        src_rnd;

`ifdef FP_RND_SKID_EN
   logic              skid_v_q;
   logic [FP_W+5:0]   skid_urnd_q;
   logic [2:0]        skid_rnd_q;

   // Ready is simply "skid empty"; a stalled S1 parks the accepted input here.
   assign bus.in_ready_o = ~skid_v_q;
   assign src_valid      = skid_v_q | bus.in_valid_i;
   assign src_urnd       = skid_v_q ? skid_urnd_q : bus.urnd_i;
   assign src_rnd        = skid_v_q ? skid_rnd_q  : bus.rnd_i;

   // Skid buffer: fills when input arrives while S1 cannot load, drains into S1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_v_q    <= 1'b0;
         skid_urnd_q <= '0;
         skid_rnd_q  <= 3'd0;
      end else if (flush_i) begin
         skid_v_q    <= 1'b0;
      end else if (skid_v_q) begin
         if (adv1) begin
            skid_v_q <= 1'b0;
         end
      end else if (bus.in_valid_i && !adv1) begin
         skid_v_q    <= 1'b1;
         skid_urnd_q <= bus.urnd_i;
         skid_rnd_q  <= bus.rnd_i;
      end
   end
`else
   assign bus.in_ready_o = adv1;
   assign src_valid      = bus.in_valid_i;
   assign src_urnd       = bus.urnd_i;
   assign src_rnd        = bus.rnd_i;
`endif

   // ---------------- S1 decision ----------------
   logic [FP_W-1:0] src_u;
   logic [1:0]      src_rs;
   logic            src_ren, src_inv;
   logic [1:0]      src_ec;
   logic            g_bit, s_bit, lsb_bit, sign_bit;
   logic            up_raw, dec_up, dec_nx;

   assign {src_u, src_rs, src_ren, src_inv, src_ec} = src_urnd;
   assign g_bit    = src_rs[1];
   assign s_bit    = src_rs[0];
   assign lsb_bit  = src_u[0];
   assign sign_bit = src_u[FP_W-1];

   // Round-up decision per rounding mode from guard/sticky/lsb/sign.
   always_comb begin
      up_raw = 1'b0;
      case (src_rnd)
         RM_RNE:  up_raw = g_bit & (s_bit | lsb_bit);
         RM_RTZ:  up_raw = 1'b0;
         RM_RDN:  up_raw = (g_bit | s_bit) & sign_bit;
         RM_RUP:  up_raw = (g_bit | s_bit) & ~sign_bit;
         RM_RMM:  up_raw = g_bit;
         default: up_raw = 1'b0;
      endcase
   end

   // Invalid results are already canonical NaNs and must pass untouched.
   assign dec_up = up_raw & src_ren & ~src_inv;
   assign dec_nx = (g_bit | s_bit) & src_ren;

   logic            s1_sign_q, s1_up_q, s1_nx_q, s1_ren_q, s1_inv_q;
   logic [EM_W-1:0] s1_em_q;
   logic [1:0]      s1_ec_q;
   logic [2:0]      s1_rm_q;

   // S1 register: input fields plus the round-up decision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q      <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_em_q   <= '0;
         s1_up_q   <= 1'b0;
         s1_nx_q   <= 1'b0;
         s1_ren_q  <= 1'b0;
         s1_inv_q  <= 1'b0;
         s1_ec_q   <= 2'd0;
         s1_rm_q   <= 3'd0;
      end else if (flush_i) begin
         v1_q      <= 1'b0;
      end else if (adv1) begin
         v1_q <= src_valid;
         if (src_valid) begin
            s1_sign_q <= sign_bit;
            s1_em_q   <= src_u[EM_W-1:0];
            s1_up_q   <= dec_up;
            s1_nx_q   <= dec_nx;
            s1_ren_q  <= src_ren;
            s1_inv_q  <= src_inv;
            s1_ec_q   <= src_ec;
            s1_rm_q   <= src_rnd;
         end
      end
   end

   // ---------------- S2 apply ----------------
   // Single add over {exp, mant}: a mantissa carry naturally bumps the exponent.
   logic [EM_W-1:0] em_sum;
   assign em_sum = s1_em_q + {{(EM_W-1){1'b0}}, s1_up_q};

   logic            s2_sign_q, s2_nx_q, s2_ren_q, s2_inv_q;
   logic [EM_W-1:0] s2_em_q;
   logic [1:0]      s2_ec_q;
   logic [2:0]      s2_rm_q;

   // S2 register: incremented magnitude and the flags context.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v2_q      <= 1'b0;
         s2_sign_q <= 1'b0;
         s2_em_q   <= '0;
         s2_nx_q   <= 1'b0;
         s2_ren_q  <= 1'b0;
         s2_inv_q  <= 1'b0;
         s2_ec_q   <= 2'd0;
         s2_rm_q   <= 3'd0;
      end else if (flush_i) begin
         v2_q      <= 1'b0;
      end else if (adv2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            s2_sign_q <= s1_sign_q;
            s2_em_q   <= em_sum;
            s2_nx_q   <= s1_nx_q;
            s2_ren_q  <= s1_ren_q;
            s2_inv_q  <= s1_inv_q;
            s2_ec_q   <= s1_ec_q;
            s2_rm_q   <= s1_rm_q;
         end
      end
   end

   // ---------------- output resolve ----------------
   logic            exp_all1;
   logic [EM_W-1:0] ovf_em;
   logic [FP_W-1:0] result_d;
   logic [4:0]      fflags_d;

   assign exp_all1 = &s2_em_q[EM_W-1:MANT_W];

   // Overflow saturation target: infinity unless the mode rounds toward zero
   // for this sign, in which case the largest finite magnitude.
   always_comb begin
      ovf_em = INF_EM;
      case (s2_rm_q)
         RM_RNE:  ovf_em = INF_EM;
         RM_RMM:  ovf_em = INF_EM;
         RM_RTZ:  ovf_em = MAX_EM;
         RM_RDN:  ovf_em = s2_sign_q ? INF_EM : MAX_EM;
         RM_RUP:  ovf_em = s2_sign_q ? MAX_EM : INF_EM;
         default: ovf_em = INF_EM;
      endcase
   end

   // Special cases take priority: invalid, exact pass-through, underflow, overflow.
   always_comb begin
      result_d = {s2_sign_q, s2_em_q};
      fflags_d = 5'b00000;
      if (s2_inv_q) begin
         result_d = {s2_sign_q, s2_em_q};
         fflags_d = 5'b10000;
      end else if (!s2_ren_q) begin
         result_d = {s2_sign_q, s2_em_q};
         fflags_d = 5'b00000;
      end else if (s2_ec_q[1]) begin
         result_d = {s2_sign_q, {EM_W{1'b0}}};
         fflags_d = 5'b00011;
      end else if ((s2_ec_q == 2'b01) || exp_all1) begin
         result_d = {s2_sign_q, ovf_em};
         fflags_d = 5'b00101;
      end else begin
         result_d = {s2_sign_q, s2_em_q};
         fflags_d = {4'b0000, s2_nx_q};
      end
   end

   logic [FP_W-1:0] result_q;
   logic [4:0]      fflags_q;

   // Output register: holds under stall, reloads on the same edge it is consumed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         fflags_q    <= 5'b00000;
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
      end else if (adv_out) begin
         out_valid_q <= v2_q;
         if (v2_q) begin
            result_q <= result_d;
            fflags_q <= fflags_d;
         end
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.result_o    = result_q;
   assign bus.fflags_o    = fflags_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_round_pipe
//  Directed bench for fp_round_pipe (FP32, default build). Expected results
//  are queued when an input is accepted and compared when the pipeline
//  hands a result to the writeback side.
// ---------------------------------------------------------------------------
module tb_fp_round_pipe;

   localparam logic [2:0] RNE = 3'd0;
   localparam logic [2:0] RTZ = 3'd1;
   localparam logic [2:0] RDN = 3'd2;
   localparam logic [2:0] RUP = 3'd3;
   localparam logic [2:0] RMM = 3'd4;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] res;
      logic [4:0]  fl;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   exp_t sb_q[$];

   fp_round_pipe_if #(.FP_WIDTH(32)) bus ();

   fp_round_pipe #(.FP_FORMAT(0)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: compare every output handshake against the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("out_id%0d", e.id), {27'd0, bus.result_o, bus.fflags_o},
                  {27'd0, e.res, e.fl});
         end else begin
            check("unexpected_output", {27'd0, bus.result_o, bus.fflags_o}, 64'hFFFF_FFFF_FFFF_FFFF);
         end
      end
   end

   // Drive one input, hold it until accepted (bounded), queue its expectation.
   task automatic send(input logic [7:0] id, input logic [31:0] u, input logic [1:0] rs,
                       input logic ren, input logic inv, input logic [1:0] ec,
                       input logic [2:0] rm, input logic [31:0] er, input logic [4:0] ef,
                       output int waited);
      exp_t e;
      waited = 0;
      bus.urnd_i     = {u, rs, ren, inv, ec};
      bus.rnd_i      = rm;
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      while (bus.in_ready_o !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (bus.in_ready_o === 1'b1) begin
         e.id = id; e.res = er; e.fl = ef;
         sb_q.push_back(e);
      end else begin
         check($sformatf("accept_timeout_id%0d", id), 64'd0, 64'd1);
      end
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
   endtask

   // Streaming send: must be accepted without any stall cycle.
   task automatic sendc(input logic [7:0] id, input logic [31:0] u, input logic [1:0] rs,
                        input logic ren, input logic inv, input logic [1:0] ec,
                        input logic [2:0] rm, input logic [31:0] er, input logic [4:0] ef);
      int w;
      send(id, u, rs, ren, inv, ec, rm, er, ef, w);
      check($sformatf("throughput_id%0d", id), 64'(w), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      bus.in_valid_i  = 1'b0;
      bus.urnd_i      = '0;
      bus.rnd_i       = 3'd0;
      bus.out_ready_i = 1'b0;

      // Reset state
      @(posedge clk); #1;
      check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
      check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      check("rst_result",    64'(bus.result_o),    64'd0);
      check("rst_fflags",    64'(bus.fflags_o),    64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;

      // Latency: accept at edge N, out_valid after edge N+2
      send(8'd1, 32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001, w);
      check("lat_n0", 64'(bus.out_valid_o), 64'd0);
      @(posedge clk); #1;
      check("lat_n1", 64'(bus.out_valid_o), 64'd0);
      @(posedge clk); #1;
      check("lat_n2", 64'(bus.out_valid_o), 64'd1);
      repeat (2) @(posedge clk);
      #1;

      // Rounding vectors streamed back to back
      sendc(8'd2,  32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
      sendc(8'd3,  32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RUP, 32'h40000000, 5'b00001);
      sendc(8'd4,  32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RNE, 32'h7F800000, 5'b00101);
      sendc(8'd5,  32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RTZ, 32'h7F7FFFFF, 5'b00101);
      sendc(8'd6,  32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RUP, 32'hFF7FFFFF, 5'b00101);
      sendc(8'd7,  32'hFFC00000, 2'b00, 1'b0, 1'b1, 2'b00, RNE, 32'hFFC00000, 5'b10000);
      sendc(8'd8,  32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00101);
      sendc(8'd9,  32'hBF800000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'hBF800001, 5'b00001);
      sendc(8'd10, 32'h3F800000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'h3F800000, 5'b00001);
      sendc(8'd11, 32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001);
      sendc(8'd12, 32'h3F800001, 2'b11, 1'b1, 1'b0, 2'b00, RTZ, 32'h3F800001, 5'b00001);
      sendc(8'd13, 32'h7F800000, 2'b11, 1'b0, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00000);
      sendc(8'd14, 32'h80000001, 2'b11, 1'b1, 1'b0, 2'b10, RNE, 32'h80000000, 5'b00011);
      sendc(8'd15, 32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RDN, 32'hFF800000, 5'b00101);
      sendc(8'd16, 32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RDN, 32'h7F7FFFFF, 5'b00101);
      sendc(8'd17, 32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RUP, 32'h7F800000, 5'b00101);
      sendc(8'd18, 32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RMM, 32'hFF800000, 5'b00101);
      sendc(8'd19, 32'h3F800003, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800004, 5'b00001);
      sendc(8'd20, 32'h3F800000, 2'b00, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00000);
      sendc(8'd21, 32'h7FC00000, 2'b11, 1'b1, 1'b1, 2'b00, RNE, 32'h7FC00000, 5'b10000);
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: three fill the pipe, the fourth must stall
      bus.out_ready_i = 1'b0;
      sendc(8'd30, 32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
      sendc(8'd31, 32'h3F800005, 2'b11, 1'b1, 1'b0, 2'b00, RTZ, 32'h3F800005, 5'b00001);
      sendc(8'd32, 32'hC0000000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'hC0000001, 5'b00001);
      bus.urnd_i     = {32'h40400000, 2'b10, 1'b1, 1'b0, 2'b00};
      bus.rnd_i      = RMM;
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      check("bp_in_ready_low", 64'(bus.in_ready_o),  64'd0);
      check("bp_out_valid",    64'(bus.out_valid_o), 64'd1);
      check("bp_hold_result0", 64'(bus.result_o),    64'h3F800002);
      @(posedge clk); #1;
      check("bp_hold_result1", 64'(bus.result_o),    64'h3F800002);
      check("bp_hold_fflags",  64'(bus.fflags_o),    64'd1);
      bus.out_ready_i = 1'b1;
      send(8'd33, 32'h40400000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h40400001, 5'b00001, w);
      repeat (5) @(posedge clk);
      #1;
      check("bp_drained", 64'(sb_q.size()), 64'd0);

      // Flush mid-stream: in-flight entries and the same-cycle input are dropped
      bus.out_ready_i = 1'b0;
      sendc(8'd40, 32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
      sendc(8'd41, 32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
      flush          = 1'b1;
      bus.urnd_i     = {32'h3F800000, 2'b00, 1'b0, 1'b0, 2'b00};
      bus.in_valid_i = 1'b1;
      @(posedge clk); #1;
      flush          = 1'b0;
      bus.in_valid_i = 1'b0;
      sb_q.delete();
      check("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
      bus.out_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("flush_stays_empty", 64'(bus.out_valid_o), 64'd0);
      sendc(8'd42, 32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001);
      repeat (4) @(posedge clk);
      #1;

      // Reset mid-operation discards everything
      bus.out_ready_i = 1'b0;
      sendc(8'd50, 32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
      sendc(8'd51, 32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RNE, 32'h7F800000, 5'b00101);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("mid_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      check("mid_rst_result",    64'(bus.result_o),    64'd0);
      check("mid_rst_fflags",    64'(bus.fflags_o),    64'd0);
      check("mid_rst_in_ready",  64'(bus.in_ready_o),  64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;
      sendc(8'd52, 32'hBF800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'hBF800002, 5'b00001);

      // Drain with a bounded wait
      for (int i = 0; i < 50 && sb_q.size() > 0; i++) begin
         @(posedge clk);
      end
      #1;
      check("final_drain", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
